// File: rtl/sid_frame_writer.sv
// Reads each completed register frame from the frame RAM, skips registers that match the
// shadow copy, and replays the changed ones onto the SID bus as phi2-aligned write cycles.
module sid_frame_writer #(
    parameter int CLK_DIV    = 16,
    parameter int NUM_REGS   = 25,
    parameter int RST_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_rdy,
    output logic [4:0] ram_addr,
    input  logic [7:0] ram_out,
    output logic       busy,
    output logic       overrun,
    output logic       sid_clk,
    output logic [4:0] sid_addr,
    output logic [7:0] sid_data,
    output logic       sid_cs,
    output logic       sid_rw,
    output logic       sid_rst
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [4:0]    REG_LAST = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, CMP, WAIT_EDGE, WRITE} state_t;

    state_t state_reg, state_next;

    logic [DW-1:0] div_reg, div_next;
    logic          sid_clk_reg;
    logic          sid_posedge;
    logic [RW-1:0] rst_cnt_reg;
    logic          sid_rst_reg;

    logic [4:0] reg_cnt_reg, reg_cnt_next;
    logic [7:0] wr_data_reg, wr_data_next;
    logic       pending_reg, pending_next;
    logic       force_all_reg, force_all_next;
    logic [4:0] ram_addr_reg, ram_addr_next;
    logic [4:0] sid_addr_reg, sid_addr_next;
    logic [7:0] sid_data_reg, sid_data_next;
    logic       sid_cs_reg, sid_cs_next;
    logic       sid_rw_reg, sid_rw_next;
    logic       busy_reg, busy_next;
    logic       overrun_reg, overrun_next;
    logic       shadow_we;
    logic       advance;
    logic       frame_req;

    logic [NUM_REGS-1:0][7:0] last_frame;

    // Phi2 is registered from the next divider count so it stays aligned with div_reg.
    assign div_next    = (div_reg == DIV_LAST) ? '0 : div_reg + DW'(1);
    assign sid_posedge = (div_reg == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_reg     <= '0;
            sid_clk_reg <= 1'b1;
        end else begin
            div_reg     <= div_next;
            sid_clk_reg <= (div_next < DIV_HALF);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_cnt_reg <= '0;
            sid_rst_reg <= 1'b0;
        end else if (!sid_rst_reg && sid_posedge) begin
            if (rst_cnt_reg == RST_LAST) begin
                sid_rst_reg <= 1'b1;
            end else begin
                rst_cnt_reg <= rst_cnt_reg + RW'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_shadow
            logic [7:0] entry_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (shadow_we && reg_cnt_reg == 5'(gi)) begin
                    entry_reg <= wr_data_reg;
                end
            end
            assign last_frame[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            reg_cnt_reg   <= '0;
            wr_data_reg   <= '0;
            pending_reg   <= 1'b0;
            force_all_reg <= 1'b1;
            ram_addr_reg  <= '0;
            sid_addr_reg  <= '0;
            sid_data_reg  <= '0;
            sid_cs_reg    <= 1'b1;
            sid_rw_reg    <= 1'b1;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            reg_cnt_reg   <= reg_cnt_next;
            wr_data_reg   <= wr_data_next;
            pending_reg   <= pending_next;
            force_all_reg <= force_all_next;
            ram_addr_reg  <= ram_addr_next;
            sid_addr_reg  <= sid_addr_next;
            sid_data_reg  <= sid_data_next;
            sid_cs_reg    <= sid_cs_next;
            sid_rw_reg    <= sid_rw_next;
            busy_reg      <= busy_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        reg_cnt_next   = reg_cnt_reg;
        wr_data_next   = wr_data_reg;
        pending_next   = pending_reg;
        force_all_next = force_all_reg;
        ram_addr_next  = ram_addr_reg;
        sid_addr_next  = sid_addr_reg;
        sid_data_next  = sid_data_reg;
        sid_cs_next    = sid_cs_reg;
        sid_rw_next    = sid_rw_reg;
        overrun_next   = 1'b0;
        shadow_we      = 1'b0;
        advance        = 1'b0;
        // Frames are not accepted while the SID chip is still held in reset.
        frame_req      = frame_rdy && sid_rst_reg;

        case (state_reg)
            IDLE: begin
                if (frame_req || pending_reg) begin
                    state_next    = FETCH;
                    reg_cnt_next  = '0;
                    ram_addr_next = '0;
                    // A new request landing on top of a pending one stays buffered.
                    pending_next  = pending_reg && frame_req;
                end
            end
            FETCH: begin
                state_next = CMP;
            end
            CMP: begin
                if (force_all_reg || ram_out != last_frame[reg_cnt_reg]) begin
                    wr_data_next = ram_out;
                    state_next   = WAIT_EDGE;
                end else begin
                    advance = 1'b1;
                end
            end
            WAIT_EDGE: begin
                if (sid_posedge) begin
                    sid_addr_next = reg_cnt_reg;
                    sid_data_next = wr_data_reg;
                    sid_cs_next   = 1'b0;
                    sid_rw_next   = 1'b0;
                    state_next    = WRITE;
                end
            end
            WRITE: begin
                if (sid_posedge) begin
                    sid_cs_next = 1'b1;
                    sid_rw_next = 1'b1;
                    shadow_we   = 1'b1;
                    advance     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (advance) begin
            if (reg_cnt_reg == REG_LAST) begin
                force_all_next = 1'b0;
                state_next     = IDLE;
            end else begin
                reg_cnt_next  = reg_cnt_reg + 5'd1;
                ram_addr_next = reg_cnt_reg + 5'd1;
                state_next    = FETCH;
            end
        end

        if (state_reg != IDLE && frame_req) begin
            if (pending_reg) begin
                overrun_next = 1'b1;
            end else begin
                pending_next = 1'b1;
            end
        end

        busy_next = (state_next != IDLE);
    end

    assign ram_addr = ram_addr_reg;
    assign busy     = busy_reg;
    assign overrun  = overrun_reg;
    assign sid_clk  = sid_clk_reg;
    assign sid_addr = sid_addr_reg;
    assign sid_data = sid_data_reg;
    assign sid_cs   = sid_cs_reg;
    assign sid_rw   = sid_rw_reg;
    assign sid_rst  = sid_rst_reg;

endmodule

// File: tb/tb_sid_frame_writer.sv
// Self-checking bench: a registered RAM model feeds the writer, a bus monitor pops
// expected (addr,data) writes from a scoreboard queue as each SID write cycle completes.
module tb_sid_frame_writer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_rdy = 1'b0;
    logic [4:0] ram_addr;
    logic [7:0] ram_out;
    logic       busy;
    logic       overrun;
    logic       sid_clk;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic       sid_cs;
    logic       sid_rw;
    logic       sid_rst;

    logic [7:0]  ram_mem [32];
    logic [12:0] exp_q [$];

    int tests_run = 0;
    int tests_failed = 0;
    int write_count = 0;
    int overrun_count = 0;

    sid_frame_writer #(.CLK_DIV(16), .NUM_REGS(25), .RST_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .frame_rdy(frame_rdy),
        .ram_addr(ram_addr), .ram_out(ram_out),
        .busy(busy), .overrun(overrun),
        .sid_clk(sid_clk), .sid_addr(sid_addr), .sid_data(sid_data),
        .sid_cs(sid_cs), .sid_rw(sid_rw), .sid_rst(sid_rst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_out <= ram_mem[ram_addr];

    // Bus monitor: one line per completed SID write.
    logic       in_wr = 1'b0;
    logic       prev_sid_clk = 1'b1;
    logic       wr_stable;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    int         low_cnt;
    int         fall_cnt;
    logic [12:0] exp_e;

    always @(negedge clk) begin
        if (overrun === 1'b1) overrun_count++;
        if (sid_cs === 1'b0) begin
            if (!in_wr) begin
                in_wr     = 1'b1;
                low_cnt   = 0;
                fall_cnt  = 0;
                wr_stable = 1'b1;
                wr_addr   = sid_addr;
                wr_data   = sid_data;
            end
            low_cnt++;
            if (sid_addr !== wr_addr || sid_data !== wr_data || sid_rw !== 1'b0) wr_stable = 1'b0;
            if (prev_sid_clk === 1'b1 && sid_clk === 1'b0) fall_cnt++;
        end else if (in_wr) begin
            in_wr = 1'b0;
            if (rst_n === 1'b1) begin
                write_count++;
                $display("[TB] write addr=%0d data=0x%02h low=%0d falls=%0d", wr_addr, wr_data, low_cnt, fall_cnt);
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%02h, expected no write", wr_addr, wr_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== exp_e || low_cnt != 16 || fall_cnt != 1 || !wr_stable) begin
                        tests_failed++;
                        $display("FAIL write_cycle: got addr=%0d data=0x%02h low=%0d falls=%0d stable=%0b, expected addr=%0d data=0x%02h low=16 falls=1 stable=1",
                                 wr_addr, wr_data, low_cnt, fall_cnt, wr_stable, exp_e[12:8], exp_e[7:0]);
                    end
                end
            end else begin
                $display("[TB] write aborted by reset addr=%0d", wr_addr);
            end
        end
        prev_sid_clk = sid_clk;
    end

    task automatic pulse_frame();
        @(negedge clk);
        frame_rdy = 1'b1;
        @(negedge clk);
        frame_rdy = 1'b0;
    endtask

    // Counts negedge samples with busy high (starting from the current one).
    task automatic wait_busy_low(input int limit, output int cycles, output logic timed_out);
        cycles = 0;
        while (busy === 1'b1 && cycles < limit) begin
            cycles++;
            @(negedge clk);
        end
        timed_out = (busy === 1'b1);
    endtask

    task automatic wait_cs_low(input int limit, output logic timed_out);
        int n = 0;
        while (sid_cs !== 1'b0 && n < limit) begin
            n++;
            @(negedge clk);
        end
        timed_out = (sid_cs !== 1'b0);
    endtask

    task automatic test_reset();
        int first_rst = 0;
        int rise1 = 0;
        int rise2 = 0;
        logic prev_clk;
        logic busy_seen = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if ({sid_clk, sid_cs, sid_rw, sid_rst, sid_addr, sid_data, ram_addr, busy, overrun} !==
            {1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 5'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_values: got clk=%b cs=%b rw=%b rst=%b addr=%0d data=%0d ram_addr=%0d busy=%b ovr=%b",
                     sid_clk, sid_cs, sid_rw, sid_rst, sid_addr, sid_data, ram_addr, busy, overrun);
        end
        rst_n = 1'b1;
        prev_clk = sid_clk;
        for (int k = 1; k <= 260; k++) begin
            frame_rdy = (k == 100);
            @(negedge clk);
            if (sid_rst === 1'b1 && first_rst == 0) first_rst = k;
            if (prev_clk === 1'b0 && sid_clk === 1'b1) begin
                if (rise1 == 0) rise1 = k;
                else if (rise2 == 0) rise2 = k;
            end
            prev_clk = sid_clk;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        frame_rdy = 1'b0;
        $display("[TB] reset: sid_rst high at clk %0d, sid_clk rises at %0d and %0d", first_rst, rise1, rise2);
        tests_run++;
        if (rise2 - rise1 != 16) begin
            tests_failed++;
            $display("FAIL sid_clk_period: got %0d, expected 16", rise2 - rise1);
        end
        tests_run++;
        if (first_rst != 241) begin
            tests_failed++;
            $display("FAIL sid_rst_release: got clk %0d, expected 241", first_rst);
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if (busy_seen || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_during_sid_rst: got busy_seen=%b busy=%b, expected 0 0", busy_seen, busy);
        end
    endtask

    task automatic test_first_frame();
        int cyc;
        logic to;
        int base = write_count;
        for (int i = 0; i < 25; i++) begin
            ram_mem[i] = 8'(8'h40 + i);
            exp_q.push_back({5'(i), 8'(8'h40 + i)});
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_before_frame: got busy=%b, expected 0", busy);
        end
        pulse_frame();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_latency: got busy=%b one clk after frame_rdy, expected 1", busy);
        end
        wait_busy_low(3000, cyc, to);
        @(negedge clk);
        $display("[TB] first frame: busy %0d clks, %0d writes", cyc, write_count - base);
        tests_run++;
        if (to || write_count - base != 25 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL first_frame: got timeout=%b writes=%0d left=%0d, expected 0 25 0", to, write_count - base, exp_q.size());
        end
    endtask

    task automatic test_identical_frame();
        int cyc;
        logic to;
        int base = write_count;
        pulse_frame();
        wait_busy_low(3000, cyc, to);
        @(negedge clk);
        $display("[TB] identical frame: busy %0d clks, %0d writes", cyc, write_count - base);
        tests_run++;
        if (to || cyc != 50 || write_count - base != 0) begin
            tests_failed++;
            $display("FAIL identical_frame: got timeout=%b busy=%0d writes=%0d, expected 0 50 0", to, cyc, write_count - base);
        end
    endtask

    task automatic test_two_changes();
        int cyc;
        logic to;
        int base = write_count;
        ram_mem[4]  = 8'hAA;
        ram_mem[24] = 8'h55;
        exp_q.push_back({5'd4, 8'hAA});
        exp_q.push_back({5'd24, 8'h55});
        pulse_frame();
        wait_busy_low(3000, cyc, to);
        @(negedge clk);
        $display("[TB] two changes: busy %0d clks, %0d writes", cyc, write_count - base);
        tests_run++;
        if (to || write_count - base != 2 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL two_changes: got timeout=%b writes=%0d left=%0d, expected 0 2 0", to, write_count - base, exp_q.size());
        end
    endtask

    task automatic test_buffering();
        int cyc;
        logic to;
        logic to_cs;
        int base = write_count;
        int ovr_base = overrun_count;
        ram_mem[10] = 8'h11;
        exp_q.push_back({5'd10, 8'h11});
        exp_q.push_back({5'd0, 8'h22});
        pulse_frame();
        repeat (3) @(negedge clk);
        pulse_frame();
        repeat (3) @(negedge clk);
        pulse_frame();
        wait_cs_low(200, to_cs);
        // Register 0 was already fetched by this frame; only the buffered one sees the change.
        ram_mem[0] = 8'h22;
        wait_busy_low(3000, cyc, to);
        @(negedge clk);
        tests_run++;
        if (to_cs || to || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL pending_restart: got timeout=%b/%b busy=%b one clk after drop, expected 0/0 1", to_cs, to, busy);
        end
        wait_busy_low(3000, cyc, to);
        repeat (40) @(negedge clk);
        $display("[TB] buffering: %0d writes, %0d overrun pulses", write_count - base, overrun_count - ovr_base);
        tests_run++;
        if (to || busy !== 1'b0 || write_count - base != 2 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL buffered_frame: got timeout=%b busy=%b writes=%0d left=%0d, expected 0 0 2 0",
                     to, busy, write_count - base, exp_q.size());
        end
        tests_run++;
        if (overrun_count - ovr_base != 1) begin
            tests_failed++;
            $display("FAIL overrun_pulse: got %0d pulses, expected 1", overrun_count - ovr_base);
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        int n = 0;
        logic to;
        int base;
        ram_mem[3] = 8'h77;
        pulse_frame();
        wait_cs_low(300, to);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (to || sid_cs !== 1'b1 || busy !== 1'b0 || sid_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_write: got timeout=%b cs=%b busy=%b sid_rst=%b, expected 0 1 0 0", to, sid_cs, busy, sid_rst);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        while (sid_rst !== 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        base = write_count;
        for (int i = 0; i < 25; i++) exp_q.push_back({5'(i), ram_mem[i]});
        pulse_frame();
        wait_busy_low(3000, cyc, to);
        @(negedge clk);
        $display("[TB] after mid-write reset: %0d writes", write_count - base);
        tests_run++;
        if (to || n >= 400 || write_count - base != 25 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rewrite_after_reset: got timeout=%b writes=%0d left=%0d, expected 0 25 0", to, write_count - base, exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram_mem[i] = 8'h00;
        test_reset();
        test_first_frame();
        test_identical_frame();
        test_two_changes();
        test_buffering();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish before 900000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
